alu_issue_stage: RTL
====================

# alu_issue_stage

Registered issue stage that drives the execute-stage ALU operand and control interface. It sits between decode/register-read and the ALU. It decodes the 32-bit MIPS instruction into the 4-bit ALU operation code and the `a`/`b` operands, and holds the result in a one-entry pipeline register. The register uses a valid/ready handshake with stall and flush support.

## Interface
Parameters:
- None.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  upstream holds a decoded-ready instruction
- `in_ready`  out  1  stage can accept this cycle
- `instr`  in  32  instruction word
- `rs_val`  in  32  forwarded rs register value
- `rt_val`  in  32  forwarded rt register value
- `link_val`  in  32  PC+8 for `jal`
- `flush`  in  1  discard held and incoming instruction
- `ex_ready`  in  1  ALU/EX stage consumes `out_*` this cycle
- `out_valid`  out  1  `out_*` fields are meaningful
- `out_a`  out  32  ALU `a` operand (shift amount for shifts)
- `out_b`  out  32  ALU `b` operand
- `out_aluc`  out  4  ALU operation code
- `out_wreg`  out  5  destination register number
- `out_wen`  out  1  register write enable
- `out_illegal`  out  1  undefined opcode/funct

## Operation
ALU codes:
- 0000 addu
- 0001 subu
- 0010 add
- 0011 sub
- 0100 and
- 0101 or
- 0110 xor
- 0111 nor
- 1000 lui
- 1010 sltu
- 1011 slt
- 1100 sra
- 1101 srl
- 1110 sll
- 1111 pass-a

R-type (op=000000), `wreg`=rd, `wen`=1, `a`=`rs_val`, `b`=`rt_val`, unless noted. Listed as funct → code:
- 100000 → 0010
- 100001 → 0000
- 100010 → 0011
- 100011 → 0001
- 100100 → 0100
- 100101 → 0101
- 100110 → 0110
- 100111 → 0111
- 101010 → 1011
- 101011 → 1010
- Immediate-amount shifts: 000000 → 1110, 000010 → 1101, 000011 → 1100, each with `a`={27'b0, instr[10:6]}.
- Variable shifts: 000100 → 1110, 000110 → 1101, 000111 → 1100, each with `a`=`rs_val`.
- 001000 jr → 1111, `wen`=0.

I-type, `wreg`=rt, `a`=`rs_val`. SE = sign-extended imm16, ZE = zero-extended imm16. Listed as opcode → code, `b`:
- addi 001000 → 0010, SE
- addiu 001001 → 0000, SE
- slti 001010 → 1011, SE
- sltiu 001011 → 1010, SE
- andi 001100 → 0100, ZE
- ori 001101 → 0101, ZE
- xori 001110 → 0110, ZE
- lui 001111 → 1000, ZE
- lw 100011 → 0000, SE
- sw 101011 → 0000, SE, `wen`=0
- beq 000100 / bne 000101 → 0011, `b`=`rt_val`, `wen`=0

Jumps:
- j 000010 → 1111, `a`=0, `wen`=0.
- jal 000011 → 1111, `a`=`link_val`, `wreg`=31, `wen`=1.

Any `wreg`=0 forces `wen`=0.

Undefined op/funct: `aluc`=1111, `a`=0, `b`=0, `wen`=0, `out_illegal` per Configuration.

Handshake:
- `in_ready` = !`out_valid` | `ex_ready`, combinational. It is never gated by `in_valid`.
- Load occurs when `in_valid` & `in_ready`. `out_valid`←1 and all `out_*` are registered from the decode.
- Output is consumed when `out_valid` & `ex_ready`. If no load happens in the same cycle, `out_valid`←0.
- Stall: when `out_valid`=1 and `ex_ready`=0, all `out_*` hold bit-exact.
- When `out_valid`=0, the `out_*` data fields retain their last value. Consumers ignore them.

## Timing
- Latency: 1 cycle from accepted input to `out_valid`. Throughput is 1 per cycle while `ex_ready`=1.
- Reset: all outputs are 0 in the cycle after `reset` is sampled high. This covers `out_valid`, `out_a`, `out_b`, `out_aluc`, `out_wreg`, `out_wen` and `out_illegal`. `in_ready` reads 1 once `out_valid`=0.
- Reset mid-stall drops the held instruction. `reset` has priority over `flush` and load.
- `flush`=1: next cycle `out_valid`=0 and `out_wen`=0. A simultaneous input is not loaded. `in_ready` still follows its formula, but the transfer is discarded.
- Simultaneous consume and load: the new instruction replaces the old one with no bubble.

## Configuration
- `ALU_ISSUE_ILLEGAL_EN` defined: undefined encodings set `out_illegal`=1, registered with the instruction and cleared by flush or reset.
- Not defined: `out_illegal` is tied 0. Undefined encodings still issue as a pass-a NOP with `wen`=0.

## Test plan
- `addi $t1,$t0,-1` (0x2109FFFF), `rs_val`=5, `ex_ready`=1 → one cycle later `out_valid`=1, `aluc`=0010, `a`=5, `b`=0xFFFFFFFF, `wreg`=9, `wen`=1.
- `sra $t2,$t3,4` (0x000B5103), `rt_val`=0x80000000 → `aluc`=1100, `a`=4, `b`=0x80000000, `wreg`=10.
- Back-to-back `ori` then `lui` with `ex_ready`=0 for 3 cycles after the first load → `in_ready`=0, `ori` fields are held stable for 3 cycles, and `lui` appears the cycle after `ex_ready` rises.
- Load `jal` (`link_val`=0x00400010) and assert `flush` the same cycle the next instruction is offered → `jal` presented as `a`=0x00400010, `wreg`=31; the next cycle `out_valid`=0.
- Opcode 0x3F with the macro defined → `out_illegal`=1, `aluc`=1111, `wen`=0. Without the macro → `out_illegal`=0.
- Assert `reset` during a stall with `out_valid`=1 → the next cycle all outputs are 0 and `in_ready`=1.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: registered issue stage feeding the execute-stage ALU.
// Decodes a 32-bit MIPS instruction into the ALU operation code and the
// a/b operands. The result sits in a one-entry valid/ready pipeline register
// with stall and flush support.
//
// Optional feature macro: ALU_ISSUE_ILLEGAL_EN. When it is defined, undefined
// encodings raise out_illegal. When it is undefined, out_illegal is tied to 0.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake (in_ready is combinational)
//   instr               instruction word
//   rs_val, rt_val      forwarded register values
//   link_val            PC+8, used by jal
//   flush               discard the held and the incoming instruction
//   ex_ready            EX stage consumes out_* this cycle
//   out_valid           out_* fields are meaningful
//   out_a, out_b        ALU operands (out_a is the shift amount for shifts)
//   out_aluc            ALU operation code
//   out_wreg, out_wen   destination register and its write enable
//   out_illegal         undefined opcode/funct (feature-dependent)
module alu_issue_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [31:0] link_val,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        out_valid,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [3:0]  out_aluc,
    output logic [4:0]  out_wreg,
    output logic        out_wen,
    output logic        out_illegal
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned ALUC_W = 4;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned IMM_W  = 16;

    localparam logic [ALUC_W-1:0] ALU_ADDU = 4'b0000;
    localparam logic [ALUC_W-1:0] ALU_SUBU = 4'b0001;
    localparam logic [ALUC_W-1:0] ALU_ADD  = 4'b0010;
    localparam logic [ALUC_W-1:0] ALU_SUB  = 4'b0011;
    localparam logic [ALUC_W-1:0] ALU_AND  = 4'b0100;
    localparam logic [ALUC_W-1:0] ALU_OR   = 4'b0101;
    localparam logic [ALUC_W-1:0] ALU_XOR  = 4'b0110;
    localparam logic [ALUC_W-1:0] ALU_NOR  = 4'b0111;
    localparam logic [ALUC_W-1:0] ALU_LUI  = 4'b1000;
    localparam logic [ALUC_W-1:0] ALU_SLTU = 4'b1010;
    localparam logic [ALUC_W-1:0] ALU_SLT  = 4'b1011;
    localparam logic [ALUC_W-1:0] ALU_SRA  = 4'b1100;
    localparam logic [ALUC_W-1:0] ALU_SRL  = 4'b1101;
    localparam logic [ALUC_W-1:0] ALU_SLL  = 4'b1110;
    localparam logic [ALUC_W-1:0] ALU_PASS = 4'b1111;

    localparam logic [REG_W-1:0]  REG_RA   = 5'd31;

    // Instruction fields
    logic [OP_W-1:0]  opcode;
    logic [OP_W-1:0]  funct;
    logic [REG_W-1:0] rt_num;
    logic [REG_W-1:0] rd_num;
    logic [REG_W-1:0] shamt;
    logic [IMM_W-1:0] imm16;
    logic [XLEN-1:0]  imm_se;
    logic [XLEN-1:0]  imm_ze;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign rt_num = instr[20:16];
    assign rd_num = instr[15:11];
    assign shamt  = instr[10:6];
    assign imm16  = instr[15:0];
    assign imm_se = {{(XLEN-IMM_W){imm16[IMM_W-1]}}, imm16};
    assign imm_ze = XLEN'(imm16);

    // The rs field is not needed: rs_val arrives already forwarded.
    logic unused_rs_field;
    assign unused_rs_field = ^instr[25:21];

    // Decode results
    logic [XLEN-1:0]   dec_a;
    logic [XLEN-1:0]   dec_b;
    logic [ALUC_W-1:0] dec_aluc;
    logic [REG_W-1:0]  dec_wreg;
    logic              dec_wen;
    logic              dec_ill;

    logic load;

    // Handshake: a slot is free when empty or when it is drained this cycle.
    assign in_ready = !out_valid || ex_ready;
    assign load     = in_valid && in_ready;

    // Instruction decode
    always_comb begin
        dec_a    = rs_val;
        dec_b    = rt_val;
        dec_aluc = ALU_PASS;
        dec_wreg = rd_num;
        dec_wen  = 1'b0;
        dec_ill  = 1'b0;

        unique case (opcode)
            6'b000000: begin
                dec_wen = 1'b1;
                unique case (funct)
                    6'b100000: dec_aluc = ALU_ADD;
                    6'b100001: dec_aluc = ALU_ADDU;
                    6'b100010: dec_aluc = ALU_SUB;
                    6'b100011: dec_aluc = ALU_SUBU;
                    6'b100100: dec_aluc = ALU_AND;
                    6'b100101: dec_aluc = ALU_OR;
                    6'b100110: dec_aluc = ALU_XOR;
                    6'b100111: dec_aluc = ALU_NOR;
                    6'b101010: dec_aluc = ALU_SLT;
                    6'b101011: dec_aluc = ALU_SLTU;
                    6'b000000: begin dec_aluc = ALU_SLL; dec_a = XLEN'(shamt); end
                    6'b000010: begin dec_aluc = ALU_SRL; dec_a = XLEN'(shamt); end
                    6'b000011: begin dec_aluc = ALU_SRA; dec_a = XLEN'(shamt); end
                    6'b000100: dec_aluc = ALU_SLL;
                    6'b000110: dec_aluc = ALU_SRL;
                    6'b000111: dec_aluc = ALU_SRA;
                    6'b001000: begin dec_aluc = ALU_PASS; dec_wen = 1'b0; end
                    default:   dec_ill = 1'b1;
                endcase
            end
            6'b001000: begin dec_aluc = ALU_ADD;  dec_b = imm_se; dec_wreg = rt_num; dec_wen = 1'b1; end
            6'b001001: begin dec_aluc = ALU_ADDU; dec_b = imm_se; dec_wreg = rt_num; dec_wen = 1'b1; end
            6'b001010: begin dec_aluc = ALU_SLT;  dec_b = imm_se; dec_wreg = rt_num; dec_wen = 1'b1; end
            6'b001011: begin dec_aluc = ALU_SLTU; dec_b = imm_se; dec_wreg = rt_num; dec_wen = 1'b1; end
            6'b001100: begin dec_aluc = ALU_AND;  dec_b = imm_ze; dec_wreg = rt_num; dec_wen = 1'b1; end
            6'b001101: begin dec_aluc = ALU_OR;   dec_b = imm_ze; dec_wreg = rt_num; dec_wen = 1'b1; end
            6'b001110: begin dec_aluc = ALU_XOR;  dec_b = imm_ze; dec_wreg = rt_num; dec_wen = 1'b1; end
            6'b001111: begin dec_aluc = ALU_LUI;  dec_b = imm_ze; dec_wreg = rt_num; dec_wen = 1'b1; end
            6'b100011: begin dec_aluc = ALU_ADDU; dec_b = imm_se; dec_wreg = rt_num; dec_wen = 1'b1; end
            6'b101011: begin dec_aluc = ALU_ADDU; dec_b = imm_se; dec_wreg = rt_num; end
            6'b000100,
            6'b000101: begin dec_aluc = ALU_SUB;  dec_wreg = rt_num; end
            6'b000010: begin dec_aluc = ALU_PASS; dec_a = '0; dec_b = '0; dec_wreg = '0; end
            6'b000011: begin
                dec_aluc = ALU_PASS;
                dec_a    = link_val;
                dec_b    = '0;
                dec_wreg = REG_RA;
                dec_wen  = 1'b1;
            end
            default:   dec_ill = 1'b1;
        endcase

        // Undefined encodings issue as a harmless pass-a NOP.
        if (dec_ill) begin
            dec_aluc = ALU_PASS;
            dec_a    = '0;
            dec_b    = '0;
            dec_wreg = '0;
            dec_wen  = 1'b0;
        end

        // $zero is never written.
        if (dec_wreg == '0) begin
            dec_wen = 1'b0;
        end
    end

    // Pipeline register: reset > flush > load > consume; otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_aluc  <= '0;
            out_wreg  <= '0;
            out_wen   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_wen   <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_a     <= dec_a;
            out_b     <= dec_b;
            out_aluc  <= dec_aluc;
            out_wreg  <= dec_wreg;
            out_wen   <= dec_wen;
        end else if (out_valid && ex_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ALU_ISSUE_ILLEGAL_EN
    // Illegal flag travels with the instruction.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            out_illegal <= 1'b0;
        end else if (load) begin
            out_illegal <= dec_ill;
        end
    end
`else
    logic unused_dec_ill;
    assign unused_dec_ill = dec_ill;
    assign out_illegal    = 1'b0;
`endif

endmodule
